// File: rtl/fpm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fpm_seq_ctrl
// Description : Sequencing controller for a multi-cycle IEEE-754 single
//               precision multiplier (shift-add mantissa, truncating round).
// Revision    : 1.0 - initial release
// ============================================================================
module fpm_seq_ctrl #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     a,
  input  logic [EXP_W+FRAC_W:0]     b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     result,
  output logic                      busy
);

  localparam int M      = FRAC_W + 1;
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int ESUM_W = EXP_W + 2;
  localparam int CNT_W  = $clog2(M);

  localparam logic [CNT_W-1:0]         c_CNT_LAST = CNT_W'(M - 1);
  localparam logic signed [ESUM_W-1:0] c_EXP_MAX  = ESUM_W'((1 << EXP_W) - 1);
  localparam logic [W-1:0]             c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, (FRAC_W-1)'(0)};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MULT   = 3'd2,
    S_NORM   = 3'd3,
    S_PACK   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [W-1:0]               r_a;
  logic [W-1:0]               r_b;
  logic [2*M-1:0]             r_mcand;
  logic [M-1:0]               r_mplier;
  logic [2*M-1:0]             r_acc;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [ESUM_W-1:0]   r_esum;
  logic [FRAC_W-1:0]          r_man;
  logic                       r_sign;
  logic                       r_zero;
  logic                       r_inf;
  logic [W-1:0]               r_result;
  logic                       w_esum_ovf;
  logic                       w_esum_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_UNPACK;
      S_UNPACK: w_state_nxt = S_MULT;
      S_MULT:   if (r_cnt == c_CNT_LAST) w_state_nxt = S_NORM;
      S_NORM:   w_state_nxt = S_PACK;
      S_PACK:   w_state_nxt = S_DONE;
      S_DONE:   if (out_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Signed exponent range checks; the sign bit catches underflow below zero.
  assign w_esum_ovf = (r_esum >= c_EXP_MAX);
  assign w_esum_unf = r_esum[ESUM_W-1] || (r_esum == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_esum   <= '0;
      r_man    <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= b;
          end
        end
        S_UNPACK: begin
          r_mcand  <= {M'(0), 1'b1, r_a[FRAC_W-1:0]};
          r_mplier <= {1'b1, r_b[FRAC_W-1:0]};
          r_acc    <= '0;
          r_cnt    <= '0;
          r_sign   <= r_a[W-1] ^ r_b[W-1];
          r_esum   <= ESUM_W'({2'b00, r_a[W-2 -: EXP_W]}) + ESUM_W'({2'b00, r_b[W-2 -: EXP_W]})
                      - ESUM_W'(BIAS);
          r_zero   <= (r_a[W-2 -: EXP_W] == '0) || (r_b[W-2 -: EXP_W] == '0);
          r_inf    <= (&r_a[W-2 -: EXP_W]) || (&r_b[W-2 -: EXP_W]);
        end
        S_MULT: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_NORM: begin
          if (r_acc[2*M-1]) begin
            r_man  <= r_acc[2*M-2 -: FRAC_W];
            r_esum <= r_esum + ESUM_W'(1);
          end else begin
            r_man  <= r_acc[2*M-3 -: FRAC_W];
          end
        end
        S_PACK: begin
          if (r_inf && r_zero)  r_result <= c_QNAN;
          else if (r_inf)       r_result <= {r_sign, {EXP_W{1'b1}}, FRAC_W'(0)};
          else if (r_zero)      r_result <= {r_sign, EXP_W'(0), FRAC_W'(0)};
          else if (w_esum_ovf)  r_result <= {r_sign, {EXP_W{1'b1}}, FRAC_W'(0)};
          else if (w_esum_unf)  r_result <= {r_sign, EXP_W'(0), FRAC_W'(0)};
          else                  r_result <= {r_sign, r_esum[EXP_W-1:0], r_man};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_fpm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpm_seq_ctrl
// Description : Randomized self-checking bench for fpm_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  fpm_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact integer product of the mantissas, then truncate and classify.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    logic        s, zero, inf;
    logic [47:0] p;
    logic [22:0] man;
    ex   = int'(x[30:23]);
    ey   = int'(y[30:23]);
    s    = x[31] ^ y[31];
    zero = (ex == 0) || (ey == 0);
    inf  = (ex == 255) || (ey == 255);
    p    = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e    = ex + ey - 127;
    if (p[47]) begin
      man = p[46:24];
      e   = e + 1;
    end else begin
      man = p[45:23];
    end
    if (inf && zero) return 32'h7FC00000;
    if (inf)         return {s, 8'hFF, 23'd0};
    if (zero)        return {s, 31'd0};
    if (e >= 255)    return {s, 8'hFF, 23'd0};
    if (e <= 0)      return {s, 31'd0};
    return {s, 8'(e), man};
  endfunction

  function automatic logic [31:0] gen_op();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(40, 215)), 23'($urandom)};
  endfunction

  task automatic do_txn(input logic [31:0] ta, input logic [31:0] tb_op, input int stall);
    int          n;
    bit          seen;
    logic [31:0] exp;
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n        = 1;
    seen     = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 0; i < 40 && !seen; i++) begin
      a         = $urandom;
      b         = $urandom;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      n++;
      #1;
      if (out_valid) seen = 1'b1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp = ref_mul(ta, tb_op);
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(n), 32'd28);
    chk("result", result, exp);
    for (int i = 0; i < stall; i++) begin
      a        = $urandom;
      b        = $urandom;
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("stall_result", result, exp);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_abort_test();
    int ov_count;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'h40000000;
    b        = 32'h40400000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Accept edge plus UNPACK edge, then ten MULT edges.
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ov_count = 0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid) ov_count++;
    end
    chk("abort_no_out_valid", 32'(ov_count), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    do_txn(32'h40000000, 32'h40400000, 0);
    chk("dir_2x3", result, 32'h40C00000);
    do_txn(32'h3FC00000, 32'h3FC00000, 1);
    chk("dir_1p5sq", result, 32'h40100000);
    do_txn(32'hC0000000, 32'h3F000000, 0);
    chk("dir_neg", result, 32'hBF800000);
    do_txn(32'h7F000000, 32'h7F000000, 0);
    chk("dir_ovf", result, 32'h7F800000);
    do_txn(32'h7F800000, 32'h00000000, 0);
    chk("dir_nan", result, 32'h7FC00000);
    do_txn(32'h00800000, 32'h00800000, 0);
    chk("dir_unf", result, 32'h00000000);
    do_txn(32'h3F800000, 32'h3F800000, 10);
    do_txn(32'h40400000, 32'h40800000, 0);

    reset_abort_test();
    do_txn(32'h40000000, 32'h40400000, 0);

    for (int t = 0; t < 24; t++) do_txn(gen_op(), gen_op(), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
